line_cache_responder: RTL and testbench
=======================================

LINE_CACHE_RESPONDER -- requirements
Module: line_cache_responder

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 800, meaning stored pixels per line (x range 0..LINE_PIXELS-1).
REQ-002 SHALL have parameter MISS_CNT_W, default 16, meaning width of miss counter.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frozen  input  1  high suppresses line-buffer writes.
REQ-006 SHALL have port adc_pixel_data  input  38  {x[10:0], y[10:0], rgb565[15:0]} from first-word-fall-through ADC FIFO.
REQ-007 SHALL have port adc_pixel_ready  input  1  FIFO non-empty; adc_pixel_data valid.
REQ-008 SHALL have port adc_pixel_read  output  1  FIFO pop strobe.
REQ-009 SHALL have port request_active  input  1  foreground read request strobe, one per cycle max.
REQ-010 SHALL have port request_x  input  11  requested pixel x.
REQ-011 SHALL have port request_y  input  11  requested pixel y.
REQ-012 SHALL have port request_ready  output  1  response strobe.
REQ-013 SHALL have port request_data  output  16  response pixel, valid with request_ready.
REQ-014 SHALL have port request_miss  output  1  response is a miss, valid with request_ready.
REQ-015 SHALL have port miss_count  output  MISS_CNT_W  saturating count of misses since reset.

Function
REQ-016 SHALL hold two line banks of LINE_PIXELS x 16 bit in block RAM; bank index = y[0]; address = bank*LINE_PIXELS + x.
REQ-017 SHALL keep per bank tag_y[10:0] and tag_valid.
REQ-018 SHALL drive adc_pixel_read = adc_pixel_ready & ~rst combinationally; FIFO drained every cycle regardless of frozen.
REQ-019 On pop with frozen=0 and x < LINE_PIXELS: SHALL write rgb to bank y[0] at x and set tag_y[y[0]] <= y, tag_valid[y[0]] <= 1 in the same edge.
REQ-020 On pop with x >= LINE_PIXELS (blanking) or frozen=1: SHALL discard pixel; RAM and tags unchanged.
REQ-021 SHALL accept a request every cycle request_active=1; no back-pressure.
REQ-022 Latency SHALL be exactly 2 cycles: request sampled at edge N, request_ready=1 for one cycle after edge N+2, responses in request order.
REQ-023 Hit = request_x < LINE_PIXELS and tag_valid[request_y[0]] and tag_y[request_y[0]] == request_y, evaluated on tags at the request edge N.
REQ-024 Hit: request_data = stored pixel, request_miss=0.
REQ-025 Miss: request_data = 16'h0000, request_miss=1, request_ready still asserted.
REQ-026 Same-cycle write and request to the same address: SHALL return old RAM content (read-first); tag check uses pre-write tags.
REQ-027 miss_count SHALL increment by 1 on each miss response, saturate at all-ones, never wrap.
REQ-028 request_ready=0 cycles: request_data and request_miss SHALL hold 0.
REQ-029 Back-to-back requests SHALL produce back-to-back responses, no gaps or reordering.

Reset
REQ-030 While rst=1: request_ready=0, request_data=0, request_miss=0, miss_count=0, adc_pixel_read=0, both tag_valid=0, pipeline emptied.
REQ-031 Requests in flight when rst asserts SHALL be dropped; no response after rst deasserts.
REQ-032 RAM contents SHALL NOT be cleared by reset; invalid tags force misses until rewritten.

Verification
REQ-033 Fill y=4, x=0..799 with rgb=x; request (10,4) -> request_ready 2 cycles later, data=16'h000A, miss=0.
REQ-034 After REQ-033, request (10,6) -> miss=1, data=0, miss_count=1; push y=6 line, re-request -> data=16'h000A, miss=0, miss_count unchanged.
REQ-035 Request (800,4) and pixel with x=900 pushed -> response miss=1; x=900 pixel popped, RAM and tags unchanged.
REQ-036 frozen=1, push y=4 x=10 rgb=16'hBEEF -> FIFO popped, request (10,4) still returns 16'h000A.
REQ-037 Requests on 5 consecutive cycles with rst pulsed 1 cycle after second -> at most responses for requests issued after rst deasserts; miss_count=0 after rst; MISS_CNT_W=2 run of 5 misses -> miss_count saturates at 3.

Source files
------------

// File: rtl/line_cache_if.sv
// Pixel-FIFO and foreground-request signals shared by the line cache and its clients.
// The master drives the FIFO data and the requests; the slave is the cache.
interface line_cache_if;
  logic [37:0] adc_pixel_data;
  logic        adc_pixel_ready;
  logic        adc_pixel_read;
  logic        request_active;
  logic [10:0] request_x;
  logic [10:0] request_y;
  logic        request_ready;
  logic [15:0] request_data;
  logic        request_miss;

  modport master (
    output adc_pixel_data, adc_pixel_ready, request_active, request_x, request_y,
    input  adc_pixel_read, request_ready, request_data, request_miss
  );

  modport slave (
    input  adc_pixel_data, adc_pixel_ready, request_active, request_x, request_y,
    output adc_pixel_read, request_ready, request_data, request_miss
  );
endinterface

// File: rtl/line_cache_responder.sv
// Two-line pixel cache: fills from the ADC FIFO, answers foreground pixel reads with a
// fixed 2-cycle latency, flagging and counting misses.
module line_cache_responder #(
  parameter int unsigned LINE_PIXELS = 800,
  parameter int unsigned MISS_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frozen,
  line_cache_if.slave           bus,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int unsigned Depth = 2 * LINE_PIXELS;
  localparam int unsigned AddrW = $clog2(Depth);

  logic [15:0] mem [Depth];
  logic [10:0] tag_y [2];
  logic [1:0]  tag_valid;

  logic [10:0] px, py;
  logic [15:0] rgb;
  logic        wr_en, rd_in, hit;
  logic [AddrW-1:0] wr_addr, rd_addr;

  logic [15:0] ram_q;
  logic        s1_valid_q, s1_hit_q;
  logic        s2_valid_q, s2_hit_q;
  logic [15:0] s2_data_q;
  logic        ready_q, miss_q;
  logic [15:0] data_q;
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  assign px  = bus.adc_pixel_data[37:27];
  assign py  = bus.adc_pixel_data[26:16];
  assign rgb = bus.adc_pixel_data[15:0];

  // The FIFO is drained every cycle; blanking and frozen pixels are simply dropped.
  assign bus.adc_pixel_read = bus.adc_pixel_ready & ~rst;
  assign wr_en   = bus.adc_pixel_ready & ~rst & ~frozen & (32'(px) < LINE_PIXELS);
  assign wr_addr = AddrW'(32'(py[0]) * LINE_PIXELS + 32'(px));

  assign rd_in   = 32'(bus.request_x) < LINE_PIXELS;
  assign rd_addr = AddrW'(32'(bus.request_y[0]) * LINE_PIXELS +
                          (rd_in ? 32'(bus.request_x) : 32'd0));
  assign hit     = rd_in & tag_valid[bus.request_y[0]] &
                   (tag_y[bus.request_y[0]] == bus.request_y);

  // Block RAM, read-first: a same-edge write is not visible to the read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rgb;
    end
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 2'b00;
      tag_y[0]  <= '0;
      tag_y[1]  <= '0;
    end else if (wr_en) begin
      tag_valid[py[0]] <= 1'b1;
      tag_y[py[0]]     <= py;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_data_q  <= '0;
      ready_q    <= 1'b0;
      miss_q     <= 1'b0;
      data_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      s1_valid_q <= bus.request_active;
      s1_hit_q   <= bus.request_active & hit;
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_hit_q;
      s2_data_q  <= ram_q;
      ready_q    <= s2_valid_q;
      miss_q     <= s2_valid_q & ~s2_hit_q;
      data_q     <= (s2_valid_q & s2_hit_q) ? s2_data_q : 16'h0000;
      if (s2_valid_q && !s2_hit_q && !(&miss_cnt_q)) begin
        miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
      end
    end
  end

  assign bus.request_ready = ready_q & ~rst;
  assign bus.request_miss  = miss_q & ~rst;
  assign bus.request_data  = data_q & {16{~rst}};
  assign miss_count        = miss_cnt_q & {MISS_CNT_W{~rst}};

endmodule

// File: tb/tb_line_cache_responder.sv
// Randomized and directed bench for line_cache_responder against a line/tag/queue model;
// a second instance with a 2-bit miss counter shares the same stimulus.
module tb_line_cache_responder;
  localparam int LP = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic        frozen;
  logic [15:0] miss_count;
  logic [1:0]  miss_count2;

  line_cache_if bus ();
  line_cache_if bus2 ();

  assign bus2.adc_pixel_data  = bus.adc_pixel_data;
  assign bus2.adc_pixel_ready = bus.adc_pixel_ready;
  assign bus2.request_active  = bus.request_active;
  assign bus2.request_x       = bus.request_x;
  assign bus2.request_y       = bus.request_y;

  line_cache_responder #(.LINE_PIXELS(LP), .MISS_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .frozen(frozen), .bus(bus), .miss_count(miss_count)
  );

  line_cache_responder #(.LINE_PIXELS(LP), .MISS_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .frozen(frozen), .bus(bus2), .miss_count(miss_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        miss;
  } resp_t;

  // Model: the two stored lines, their tags, and responses waiting for their due cycle.
  resp_t       rq[$];
  logic [15:0] pix [2][LP];
  logic [10:0] ty [2];
  logic        tv [2];
  int          cyc = 0;
  int          mc = 0;
  int          mc2 = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_ready;
  logic [15:0] exp_data;
  logic        exp_miss;

  task automatic set_req(input logic [10:0] x, input logic [10:0] y);
    bus.request_active = 1'b1;
    bus.request_x      = x;
    bus.request_y      = y;
  endtask

  task automatic set_pix(input logic [10:0] x, input logic [10:0] y, input logic [15:0] c);
    bus.adc_pixel_ready = 1'b1;
    bus.adc_pixel_data  = {x, y, c};
  endtask

  // One clock: the model consumes what was driven at this edge and predicts the outputs.
  task automatic tick();
    logic r, req, pop, frz, hit, b;
    logic [10:0] rx, ry, px, py;
    logic [15:0] c;
    resp_t f;
    r = rst; req = bus.request_active; rx = bus.request_x; ry = bus.request_y;
    pop = bus.adc_pixel_ready; {px, py, c} = bus.adc_pixel_data; frz = frozen;
    @(posedge clk);
    cyc++;
    exp_ready = 1'b0; exp_data = 16'h0; exp_miss = 1'b0;
    if (r) begin
      rq.delete(); tv[0] = 1'b0; tv[1] = 1'b0; mc = 0; mc2 = 0;
    end else begin
      if (req) begin
        b = ry[0];
        hit = (int'(rx) < LP) && tv[b] && (ty[b] == ry);
        f.due = cyc + 2; f.miss = !hit; f.data = 16'h0;
        if (hit) f.data = pix[b][rx];
        rq.push_back(f);
      end
      if (pop && !frz && int'(px) < LP) begin
        pix[py[0]][px] = c; ty[py[0]] = py; tv[py[0]] = 1'b1;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        f = rq.pop_front();
        exp_ready = 1'b1; exp_data = f.data; exp_miss = f.miss;
        if (f.miss) begin
          if (mc < 65535) mc++;
          if (mc2 < 3) mc2++;
        end
      end
    end
    #1;
    bus.request_active  = 1'b0;
    bus.adc_pixel_ready = 1'b0;
  endtask

  task automatic fill_line(input logic [10:0] y);
    for (int x = 0; x < LP; x++) begin
      set_pix(11'(x), y, 16'(x));
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frozen = 1'b0;
    set_pix(11'd1, 11'd1, 16'h1111); set_req(11'd3, 11'd3);
    #1;
    n_checks++;
    if (bus.adc_pixel_read !== 1'b0) begin
      n_fail++; $display("FAIL reset_pop: got %b want 0", bus.adc_pixel_read);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.request_ready, bus.request_miss, bus.request_data, miss_count} !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b miss=%b data=%h cnt=%0d want all 0",
                 bus.request_ready, bus.request_miss, bus.request_data, miss_count);
      end
    end
    rst = 1'b0;
    set_pix(11'd900, 11'd0, 16'h1234);
    #1;
    n_checks++;
    if (bus.adc_pixel_read !== 1'b1) begin
      n_fail++; $display("FAIL pop_after_reset: got %b want 1", bus.adc_pixel_read);
    end
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data} !== 18'h0) begin
      n_fail++; $display("FAIL idle_after_reset: got rdy=%b miss=%b data=%h want 0",
                         bus.request_ready, bus.request_miss, bus.request_data);
    end
  endtask

  task automatic test_fill_hit();
    fill_line(11'd4);
    set_req(11'd10, 11'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (i == 2) begin
        if ({bus.request_ready, bus.request_miss, bus.request_data} !== {2'b10, 16'h000A}) begin
          n_fail++; $display("FAIL fill_hit: got rdy=%b miss=%b data=%h want 1 0 000a",
                             bus.request_ready, bus.request_miss, bus.request_data);
        end
      end else if ({bus.request_ready, bus.request_miss, bus.request_data} !== 18'h0) begin
        n_fail++; $display("FAIL fill_hit_idle[%0d]: got rdy=%b miss=%b data=%h want 0", i,
                           bus.request_ready, bus.request_miss, bus.request_data);
      end
    end
  endtask

  task automatic test_miss_refill();
    set_req(11'd10, 11'd6);
    repeat (3) tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data, miss_count} !==
        {2'b11, 16'h0, 16'd1}) begin
      n_fail++; $display("FAIL miss_y6: got rdy=%b miss=%b data=%h cnt=%0d want 1 1 0000 1",
                         bus.request_ready, bus.request_miss, bus.request_data, miss_count);
    end
    fill_line(11'd6);
    set_req(11'd10, 11'd6);
    repeat (3) tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data, miss_count} !==
        {2'b10, 16'h000A, 16'd1}) begin
      n_fail++; $display("FAIL refill_y6: got rdy=%b miss=%b data=%h cnt=%0d want 1 0 000a 1",
                         bus.request_ready, bus.request_miss, bus.request_data, miss_count);
    end
  endtask

  task automatic test_blanking();
    fill_line(11'd4);
    set_req(11'd800, 11'd4); set_pix(11'd900, 11'd5, 16'hFFFF);
    tick(); set_req(11'd10, 11'd4);
    tick(); set_req(11'd10, 11'd5);
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data, miss_count} !==
        {2'b11, 16'h0, 16'd2}) begin
      n_fail++; $display("FAIL x800_miss: got rdy=%b miss=%b data=%h cnt=%0d want 1 1 0000 2",
                         bus.request_ready, bus.request_miss, bus.request_data, miss_count);
    end
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data} !== {2'b10, 16'h000A}) begin
      n_fail++; $display("FAIL blank_keeps_ram: got rdy=%b miss=%b data=%h want 1 0 000a",
                         bus.request_ready, bus.request_miss, bus.request_data);
    end
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, miss_count} !== {2'b11, 16'd3}) begin
      n_fail++; $display("FAIL blank_keeps_tag: got rdy=%b miss=%b cnt=%0d want 1 1 3",
                         bus.request_ready, bus.request_miss, miss_count);
    end
  endtask

  task automatic test_frozen();
    frozen = 1'b1;
    set_pix(11'd10, 11'd4, 16'hBEEF);
    #1;
    n_checks++;
    if (bus.adc_pixel_read !== 1'b1) begin
      n_fail++; $display("FAIL frozen_pop: got %b want 1", bus.adc_pixel_read);
    end
    tick();
    set_pix(11'd20, 11'd7, 16'hBEEF);
    tick();
    frozen = 1'b0;
    set_req(11'd10, 11'd4); tick();
    set_req(11'd20, 11'd7); tick();
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data} !== {2'b10, 16'h000A}) begin
      n_fail++; $display("FAIL frozen_ram: got rdy=%b miss=%b data=%h want 1 0 000a",
                         bus.request_ready, bus.request_miss, bus.request_data);
    end
    tick();
    n_checks++;
    if ({bus.request_ready, bus.request_miss, bus.request_data} !== {2'b11, 16'h0}) begin
      n_fail++; $display("FAIL frozen_tag: got rdy=%b miss=%b data=%h want 1 1 0000",
                         bus.request_ready, bus.request_miss, bus.request_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [10:0] sx [4] = '{11'd10, 11'd10, 11'd12, 11'd12};
    logic [10:0] sy [4] = '{11'd4, 11'd4, 11'd8, 11'd8};
    logic [17:0] want [4] = '{{2'b10, 16'h000A}, {2'b10, 16'h5555},
                              {2'b11, 16'h0000}, {2'b10, 16'h7777}};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_req(sx[i], sy[i]);
      if (i == 0) set_pix(11'd10, 11'd4, 16'h5555);
      if (i == 2) set_pix(11'd12, 11'd8, 16'h7777);
      tick();
      if (i >= 2) begin
        n_checks++;
        if ({bus.request_ready, bus.request_miss, bus.request_data} !== want[i-2]) begin
          n_fail++; $display("FAIL read_first[%0d]: got %b %b %h want %h", i - 2,
                             bus.request_ready, bus.request_miss, bus.request_data, want[i-2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_line(11'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_req(11'(100 + i), 11'd1);
      tick();
      if (i >= 2) begin
        n_checks++;
        if ({bus.request_ready, bus.request_miss, bus.request_data} !==
            {2'b10, 16'(100 + i - 2)}) begin
          n_fail++; $display("FAIL back_to_back[%0d]: got rdy=%b miss=%b data=%h want 1 0 %h",
                             i - 2, bus.request_ready, bus.request_miss, bus.request_data,
                             16'(100 + i - 2));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] ylist [4] = '{11'd1, 11'd4, 11'd8, 11'd3};
    for (int i = 0; i < 403; i++) begin
      if (i < 400) begin
        frozen = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) != 0)
          set_req(11'($urandom_range(0, 1023)), ylist[$urandom_range(0, 3)]);
        if ($urandom_range(0, 1) == 0)
          set_pix(11'($urandom_range(0, 1023)), ylist[$urandom_range(0, 3)], 16'($urandom));
      end else begin
        frozen = 1'b0;
      end
      tick();
      n_checks++;
      if ({bus.request_ready, bus.request_miss, bus.request_data} !==
          {exp_ready, exp_miss, exp_data}) begin
        n_fail++; $display("FAIL random_resp[%0d]: got %b %b %h want %b %b %h", i,
                           bus.request_ready, bus.request_miss, bus.request_data,
                           exp_ready, exp_miss, exp_data);
      end
      n_checks++;
      if (miss_count !== 16'(mc) || miss_count2 !== 2'(mc2)) begin
        n_fail++; $display("FAIL random_count[%0d]: got %0d/%0d want %0d/%0d", i,
                           miss_count, miss_count2, mc, mc2);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n_resp = 0;
    for (int i = 0; i < 8; i++) begin
      rst = (i == 2);
      if (i < 5) set_req(11'd10, 11'd8);
      tick();
      if (bus.request_ready === 1'b1) n_resp++;
      n_checks++;
      if ({bus.request_ready, bus.request_miss, bus.request_data} !==
          {exp_ready, exp_miss, exp_data}) begin
        n_fail++; $display("FAIL inflight[%0d]: got %b %b %h want %b %b %h", i,
                           bus.request_ready, bus.request_miss, bus.request_data,
                           exp_ready, exp_miss, exp_data);
      end
      if (i == 2) begin
        n_checks++;
        if (miss_count !== 16'd0 || miss_count2 !== 2'd0) begin
          n_fail++; $display("FAIL count_reset: got %0d/%0d want 0/0", miss_count, miss_count2);
        end
      end
    end
    rst = 1'b0;
    n_checks++;
    if (n_resp !== 2) begin
      n_fail++; $display("FAIL inflight_count: got %0d responses want 2", n_resp);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_req(11'(i), 11'd9);
      tick();
    end
    n_checks++;
    if (miss_count !== 16'd7 || miss_count2 !== 2'd3) begin
      n_fail++; $display("FAIL saturate: got %0d/%0d want 7/3", miss_count, miss_count2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frozen = 1'b0;
    bus.request_active = 1'b0; bus.request_x = '0; bus.request_y = '0;
    bus.adc_pixel_ready = 1'b0; bus.adc_pixel_data = '0;
    tv[0] = 1'b0; tv[1] = 1'b0;
    test_reset();
    test_fill_hit();
    test_miss_refill();
    test_blanking();
    test_frozen();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
